spmp_lsu_resp_queue: RTL and testbench

- Downstream stage of the SPMP checker's LSU port. Buffers the registered SPMP results (paddr, access kind, exception) in a small in-order FIFO and presents them to the load/store unit with a valid/ready handshake.
- Enforces precise exceptions: once a faulting result is queued, later results are discarded until the fault is consumed or a flush arrives.
- Reports overflow, because the SPMP stage has no backpressure.

---
 rtl/spmp_lsu_resp_queue_pkg.sv | 23 ++
 rtl/spmp_resp_fifo.sv | 76 +++++++
 rtl/spmp_lsu_resp_queue.sv | 129 ++++++++++++
 tb/tb_spmp_lsu_resp_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmp_lsu_resp_queue_pkg.sv
// Shared types for the SPMP LSU response queue.
//  - SPMP_PLEN / SPMP_XLEN : core-level physical address and XLEN widths
//  - spmp_resp_state_e     : RUN (accepting) / HALT (fault queued, dropping)
//  - spmp_lsu_resp_t       : one queued SPMP result
package spmp_lsu_resp_queue_pkg;

   localparam int SPMP_PLEN = 56;
   localparam int SPMP_XLEN = 64;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } spmp_resp_state_e;

   typedef struct packed {
      logic [SPMP_PLEN-1:0] paddr;
      logic                 is_store;
      logic                 ex_valid;
      logic [SPMP_XLEN-1:0] ex_cause;
      logic [SPMP_XLEN-1:0] ex_tval;
   } spmp_lsu_resp_t;

endpackage

// File: rtl/spmp_resp_fifo.sv
// Generic in-order FIFO with a combinational head read.
//  clk_i, rst_i  : clock, synchronous active-high reset
//  clr_i         : synchronous clear (pointers and count to zero)
//  wr_en_i/data  : push (caller guarantees !full_o)
//  rd_en_i       : pop  (caller guarantees !empty_o)
//  rd_data_o     : head entry, valid whenever !empty_o
//  full_o/empty_o: occupancy flags
module spmp_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] entries [DEPTH];

   // Each entry is its own register so the head can be read without a
   // clock of latency; storage is never reset since empty gates its use.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q;
      always_ff @(posedge clk_i) begin
         if (wr_en_i && (wr_ptr_q == AW'(gi))) begin
            entry_q <= wr_data_i;
         end
      end
      assign entries[gi] = entry_q;
   end

   assign rd_data_o = entries[rd_ptr_q];
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/spmp_lsu_resp_queue.sv
// SPMP LSU response queue: buffers checked results for the LSU and keeps
// exceptions precise by dropping everything behind a queued fault.
//  clk_i, rst_i, flush_i       : clock, sync reset, pipeline flush
//  in_valid_i, in_*            : SPMP result (no backpressure upstream)
//  in_ready_o                  : result can be taken this cycle
//  out_valid_o, out_ready_i    : head handshake towards the LSU
//  out_*                       : head payload, zero when empty
//  overflow_o                  : sticky, a valid result met !in_ready_o
//  drop_cnt_o                  : saturating count of results dropped in HALT
module spmp_lsu_resp_queue
   import spmp_lsu_resp_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PLEN   = SPMP_PLEN,
   parameter int XLEN   = SPMP_XLEN,
   parameter int DROP_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   input  logic [PLEN-1:0]   in_paddr_i,
   input  logic              in_is_store_i,
   input  logic              in_ex_valid_i,
   input  logic [XLEN-1:0]   in_ex_cause_i,
   input  logic [XLEN-1:0]   in_ex_tval_i,
   output logic              in_ready_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PLEN-1:0]   out_paddr_o,
   output logic              out_is_store_o,
   output logic              out_ex_valid_o,
   output logic [XLEN-1:0]   out_ex_cause_o,
   output logic [XLEN-1:0]   out_ex_tval_o,
   output logic              overflow_o,
   output logic [DROP_W-1:0] drop_cnt_o
);

   localparam int ENTRY_W = $bits(spmp_lsu_resp_t);

   spmp_resp_state_e    state_q, state_d;
   logic                overflow_q, overflow_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

   spmp_lsu_resp_t      in_entry;
   spmp_lsu_resp_t      head_entry;
   logic [ENTRY_W-1:0]  fifo_rd_data;
   logic                fifo_full, fifo_empty;
   logic                in_ready, enq, deq;

   always_comb begin
      in_entry          = '0;
      in_entry.paddr    = in_paddr_i;
      in_entry.is_store = in_is_store_i;
      in_entry.ex_valid = in_ex_valid_i;
      in_entry.ex_cause = in_ex_cause_i;
      in_entry.ex_tval  = in_ex_tval_i;
   end

   // HALT always reports ready: results there are swallowed, not stored,
   // so they must not count as overflow.
   assign in_ready = (state_q == HALT) ? 1'b1 : !fifo_full;
   assign enq      = in_valid_i && in_ready && (state_q == RUN) && !flush_i;
   assign deq      = !fifo_empty && out_ready_i && !flush_i;

   spmp_resp_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (flush_i),
      .wr_en_i   (enq),
      .wr_data_i (in_entry),
      .rd_en_i   (deq),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign head_entry = fifo_empty ? '0 : spmp_lsu_resp_t'(fifo_rd_data);

   always_comb begin
      state_d    = state_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (flush_i) begin
         state_d    = RUN;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (enq && in_ex_valid_i) state_d = HALT;
            end
            HALT: begin
               if (in_valid_i && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
               // Only the faulting entry can carry ex_valid while halted.
               if (deq && head_entry.ex_valid) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
         if (in_valid_i && !in_ready) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign in_ready_o     = in_ready;
   assign out_valid_o    = !fifo_empty;
   assign out_paddr_o    = head_entry.paddr;
   assign out_is_store_o = head_entry.is_store;
   assign out_ex_valid_o = head_entry.ex_valid;
   assign out_ex_cause_o = head_entry.ex_cause;
   assign out_ex_tval_o  = head_entry.ex_tval;
   assign overflow_o     = overflow_q;
   assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_spmp_lsu_resp_queue.sv
// Directed bench for spmp_lsu_resp_queue (DEPTH=4).
module tb_spmp_lsu_resp_queue;

   localparam int DEPTH  = 4;
   localparam int PLEN   = 56;
   localparam int XLEN   = 64;
   localparam int DROP_W = 8;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              flush_i;
   logic              in_valid_i;
   logic [PLEN-1:0]   in_paddr_i;
   logic              in_is_store_i;
   logic              in_ex_valid_i;
   logic [XLEN-1:0]   in_ex_cause_i;
   logic [XLEN-1:0]   in_ex_tval_i;
   logic              in_ready_o;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [PLEN-1:0]   out_paddr_o;
   logic              out_is_store_o;
   logic              out_ex_valid_o;
   logic [XLEN-1:0]   out_ex_cause_o;
   logic [XLEN-1:0]   out_ex_tval_o;
   logic              overflow_o;
   logic [DROP_W-1:0] drop_cnt_o;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   spmp_lsu_resp_queue #(
      .DEPTH  (DEPTH),
      .PLEN   (PLEN),
      .XLEN   (XLEN),
      .DROP_W (DROP_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .in_valid_i     (in_valid_i),
      .in_paddr_i     (in_paddr_i),
      .in_is_store_i  (in_is_store_i),
      .in_ex_valid_i  (in_ex_valid_i),
      .in_ex_cause_i  (in_ex_cause_i),
      .in_ex_tval_i   (in_ex_tval_i),
      .in_ready_o     (in_ready_o),
      .out_valid_o    (out_valid_o),
      .out_ready_i    (out_ready_i),
      .out_paddr_o    (out_paddr_o),
      .out_is_store_o (out_is_store_o),
      .out_ex_valid_o (out_ex_valid_o),
      .out_ex_cause_o (out_ex_cause_o),
      .out_ex_tval_o  (out_ex_tval_o),
      .overflow_o     (overflow_o),
      .drop_cnt_o     (drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      if (out_valid_o && out_ready_i)
         $display("deq paddr=%0h store=%0b ex=%0b cause=%0h tval=%0h",
                  out_paddr_o, out_is_store_o, out_ex_valid_o, out_ex_cause_o, out_ex_tval_o);
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [PLEN-1:0] pa, input logic st,
                        input logic exv, input logic [XLEN-1:0] c, input logic [XLEN-1:0] t);
      in_valid_i    = v;
      in_paddr_i    = pa;
      in_is_store_i = st;
      in_ex_valid_i = exv;
      in_ex_cause_i = c;
      in_ex_tval_i  = t;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic push(input logic [PLEN-1:0] pa);
      drive(1'b1, pa, 1'b0, 1'b0, '0, '0);
      tick();
      idle();
   endtask

   initial begin
      rst_i       = 1'b1;
      flush_i     = 1'b0;
      out_ready_i = 1'b0;
      idle();
      tick();
      tick();
      rst_i = 1'b0;

      // Reset state
      chk("rst_in_ready", in_ready_o, 1);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_paddr", out_paddr_o, 0);
      chk("rst_is_store", out_is_store_o, 0);
      chk("rst_ex_valid", out_ex_valid_o, 0);
      chk("rst_cause", out_ex_cause_o, 0);
      chk("rst_tval", out_ex_tval_o, 0);
      chk("rst_overflow", overflow_o, 0);
      chk("rst_drop", drop_cnt_o, 0);

      // Basic load, one cycle enqueue latency, no fall-through
      drive(1'b1, 56'h8000_1000, 1'b0, 1'b0, '0, '0);
      chk("basic_no_fallthru", out_valid_o, 0);
      tick();
      idle();
      chk("basic_valid", out_valid_o, 1);
      chk("basic_paddr", out_paddr_o, 64'h8000_1000);
      chk("basic_is_store", out_is_store_o, 0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      chk("basic_drained", out_valid_o, 0);

      // Fill to full, overflow, drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, PLEN'(i * 256), (i == 2), 1'b0, '0, '0);
         tick();
      end
      idle();
      chk("full_in_ready", in_ready_o, 0);
      chk("full_no_ovf_yet", overflow_o, 0);
      drive(1'b1, 56'h500, 1'b0, 1'b0, '0, '0);
      tick();
      idle();
      chk("full_overflow", overflow_o, 1);
      out_ready_i = 1'b1;
      chk("full_ready_no_comb_path", in_ready_o, 0);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", out_valid_o, 1);
         chk("drain_paddr", out_paddr_o, 64'(i * 256));
         chk("drain_is_store", out_is_store_o, 64'(i == 2));
         tick();
      end
      out_ready_i = 1'b0;
      chk("drain_empty", out_valid_o, 0);
      chk("drain_overflow_sticky", overflow_o, 1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_clears_ovf", overflow_o, 0);

      // Precise exception: A, B(fault), C and D dropped
      push(56'h1A00);
      drive(1'b1, 56'h1B00, 1'b1, 1'b1, 64'd13, 64'hDEAD);
      tick();
      drive(1'b1, 56'h1C00, 1'b0, 1'b0, '0, '0);
      tick();
      drive(1'b1, 56'h1D00, 1'b0, 1'b0, '0, '0);
      tick();
      idle();
      chk("halt_drop_cnt", drop_cnt_o, 2);
      chk("halt_in_ready", in_ready_o, 1);
      chk("halt_no_overflow", overflow_o, 0);
      chk("exA_paddr", out_paddr_o, 64'h1A00);
      chk("exA_ex_valid", out_ex_valid_o, 0);
      out_ready_i = 1'b1;
      tick();
      chk("exB_paddr", out_paddr_o, 64'h1B00);
      chk("exB_is_store", out_is_store_o, 1);
      chk("exB_ex_valid", out_ex_valid_o, 1);
      chk("exB_cause", out_ex_cause_o, 13);
      chk("exB_tval", out_ex_tval_o, 64'hDEAD);
      tick();
      out_ready_i = 1'b0;
      chk("exCD_not_stored", out_valid_o, 0);
      push(56'h1E00);
      chk("exE_valid", out_valid_o, 1);
      chk("exE_paddr", out_paddr_o, 64'h1E00);
      chk("exE_drop_kept", drop_cnt_o, 2);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      // Simultaneous enqueue and dequeue with two entries held
      push(56'h10);
      push(56'h20);
      out_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, PLEN'(48 + 16 * k), 1'b0, 1'b0, '0, '0);
         chk("sim_head", out_paddr_o, 64'(16 + 16 * k));
         chk("sim_in_ready", in_ready_o, 1);
         tick();
      end
      idle();
      out_ready_i = 1'b0;
      chk("sim_head_after", out_paddr_o, 64'h40);
      out_ready_i = 1'b1;
      tick();
      chk("sim_second", out_paddr_o, 64'h50);
      chk("sim_second_valid", out_valid_o, 1);
      tick();
      out_ready_i = 1'b0;
      chk("sim_count_two", out_valid_o, 0);

      // Flush priority: 3 entries, HALT, overflow set, drop saturated
      for (int i = 1; i <= 4; i++) push(PLEN'(i * 256));
      drive(1'b1, 56'h4FF, 1'b0, 1'b0, '0, '0);
      tick();
      idle();
      out_ready_i = 1'b1;
      tick();
      tick();
      out_ready_i = 1'b0;
      drive(1'b1, 56'h500, 1'b0, 1'b1, 64'd5, 64'h55);
      tick();
      drive(1'b1, 56'h600, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 260; i++) tick();
      idle();
      chk("sat_drop_cnt", drop_cnt_o, 8'hFF);
      chk("pre_flush_ovf", overflow_o, 1);
      chk("pre_flush_head", out_paddr_o, 64'h300);
      flush_i     = 1'b1;
      out_ready_i = 1'b1;
      drive(1'b1, 56'h999, 1'b0, 1'b0, '0, '0);
      tick();
      flush_i     = 1'b0;
      out_ready_i = 1'b0;
      idle();
      chk("flush_out_valid", out_valid_o, 0);
      chk("flush_in_ready", in_ready_o, 1);
      chk("flush_overflow", overflow_o, 0);
      chk("flush_drop", drop_cnt_o, 0);
      chk("flush_paddr_zero", out_paddr_o, 0);
      tick();
      chk("flush_input_lost", out_valid_o, 0);
      push(56'h777);
      chk("post_flush_run", out_paddr_o, 64'h777);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;

      // Reset while full
      for (int i = 0; i < 4; i++) push(PLEN'(32'hA00 + i * 256));
      chk("pre_rst_full", in_ready_o, 0);
      rst_i       = 1'b1;
      out_ready_i = 1'b1;
      drive(1'b1, 56'hEEE, 1'b0, 1'b0, '0, '0);
      tick();
      rst_i       = 1'b0;
      out_ready_i = 1'b0;
      idle();
      chk("rst2_in_ready", in_ready_o, 1);
      chk("rst2_out_valid", out_valid_o, 0);
      chk("rst2_paddr", out_paddr_o, 0);
      chk("rst2_overflow", overflow_o, 0);
      chk("rst2_drop", drop_cnt_o, 0);
      push(56'hE00);
      push(56'hF00);
      chk("rst2_first_head", out_paddr_o, 64'hE00);
      out_ready_i = 1'b1;
      tick();
      chk("rst2_second_head", out_paddr_o, 64'hF00);
      tick();
      out_ready_i = 1'b0;
      chk("rst2_empty", out_valid_o, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
